// File: rtl/crc_code_encoder.sv
// rtl/crc_code_encoder.sv - bit-serial CRC-4 (x^4+x+1) encoder producing a 12-bit {data, crc} codeword
module crc_code_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        inject_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  crc_q, crc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  shift_q, shift_d;
  logic        inj_q, inj_d;
  logic        fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      crc_q   <= 4'h0;
      cnt_q   <= 3'd0;
      data_q  <= 8'h00;
      shift_q <= 8'h00;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      inj_q   <= inj_d;
    end
  end

  // Feedback of the MSB-first LFSR division; the message is fed without augmentation.
  assign fb = crc_q[3] ^ shift_q[7];

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    shift_d = shift_q;
    inj_d   = inj_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          shift_d = in_data;
          crc_d   = 4'h0;
          inj_d   = inject_err;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_d   = {crc_q[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        shift_d = {shift_q[6:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; in_ready is also held low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == SHIFT) || (state_q == HOLD);
  assign out_data  = out_valid ? {data_q, crc_q[3:1], crc_q[0] ^ inj_q} : 12'h000;

endmodule

// File: tb/tb_crc_code_encoder.sv
// tb/tb_crc_code_encoder.sv - directed self-checking bench for crc_code_encoder
module tb_crc_code_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        inject_err;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        busy;

  int passed;
  int total;

  crc_code_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .inject_err (inject_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Called right after the accept edge: checks latency, codeword and consumption.
  task automatic run_word(input string tag, input logic [11:0] exp_cw);
    for (int i = 0; i < 7; i++) step();
    chk({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {20'd0, out_data}, {20'd0, exp_cw});
    out_ready = 1'b1;
    step();
    chk({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    inject_err = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {20'd0, out_data}, 32'h000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Word 0x80: remainder 0xE.
    step();
    in_valid  = 1'b1;
    in_data   = 8'h80;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("w80_busy", {31'd0, busy}, 32'd1);
    chk("w80_in_ready", {31'd0, in_ready}, 32'd0);
    run_word("w80", 12'h80E);

    // Back-to-back words with in_valid held high; in_data changes while busy.
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_data = 8'hFF;
    run_word("w01", 12'h013);
    step();
    in_data = 8'h00;
    run_word("wFF", 12'hFF4);
    step();
    in_valid = 1'b0;
    run_word("w00", 12'h000);

    // Error injection, with inputs toggled while busy.
    in_valid   = 1'b1;
    in_data    = 8'hFF;
    inject_err = 1'b1;
    step();
    in_valid   = 1'b0;
    in_data    = 8'h3C;
    inject_err = 1'b0;
    step();
    in_data    = 8'hC3;
    inject_err = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("inj_valid_early", {31'd0, out_valid}, 32'd0);
    inject_err = 1'b0;
    step();
    chk("inj_valid", {31'd0, out_valid}, 32'd1);
    chk("inj_data", {20'd0, out_data}, 32'hFF5);
    step();
    chk("inj_consumed", {31'd0, out_valid}, 32'd0);

    // Backpressure: HOLD persists with stable output.
    in_valid  = 1'b1;
    in_data   = 8'h80;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {20'd0, out_data}, 32'h80E);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_one_handshake", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("bp_no_second", {31'd0, out_valid}, 32'd0);

    // Reset at the 4th shift cycle of 0xA5 discards the word.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {20'd0, out_data}, 32'h000);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_valid = 1'b0;
    run_word("post_rst_w01", 12'h013);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/crc_code_encoder.md
# crc_code_encoder

Bit-serial CRC-4 encoder that sits directly upstream of the CRC-4 decoder stage in the memory protection path. It accepts an 8-bit data word over a valid/ready handshake and computes the CRC-4 remainder (generator x^4 + x + 1) MSB-first, one bit per clock. It then presents the 12-bit codeword {data, crc} on a valid/ready output held until consumed. An optional per-word error-injection input corrupts the stored codeword so the downstream decoder's error path can be exercised.

## Interface
- No parameters; data width is fixed at 8, CRC width at 4, and the generator polynomial is fixed.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  encoder can accept a word; high only in IDLE.
- in_data  in  8  data word; sampled only on accept.
- inject_err  in  1  sampled with in_data on accept; when 1, codeword bit 0 is inverted.
- out_valid  out  1  out_data holds a complete codeword.
- out_ready  in  1  downstream consumes the codeword.
- out_data  out  12  codeword: [11:4] = data, [3:0] = CRC, or CRC with bit 0 inverted if inject_err was set.
- busy  out  1  high in SHIFT or HOLD.

## Operation
- The FSM has three states: IDLE, SHIFT and HOLD.
- IDLE
  - Drives in_ready=1.
  - Accepts when in_valid & in_ready: data_reg<=in_data, shift_reg<=in_data, crc<=4'h0, inj<=inject_err, cnt<=0, then goes to SHIFT.
- SHIFT
  - Runs 8 cycles, one bit per cycle.
  - d = shift_reg[7]; fb = crc[3]^d.
  - crc <= {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - shift_reg <= {shift_reg[6:0],1'b0}; cnt <= cnt+1.
  - When cnt==7 (the 8th shift), goes to HOLD.
- CRC definition: the final crc equals remainder(data(x)·x^4 mod x^4+x+1). No augmentation cycles are needed.
- HOLD
  - out_valid=1.
  - out_data = {data_reg, crc[3:1], crc[0]^inj}.
  - When out_valid & out_ready, returns to IDLE. The same edge does not accept a new word.
- cnt is 3 bits and wraps naturally. It is only compared in SHIFT.
- in_data and inject_err are ignored outside an accept.
- out_ready is ignored outside HOLD.
- out_data is 12'h000 whenever out_valid=0. It is stable throughout HOLD.

## Timing
- Reset values: in_ready=0 during reset, then 1 in IDLE after release. out_valid=0, out_data=12'h000, busy=0. Internal state: crc=0, cnt=0, data_reg=0, shift_reg=0, inj=0, state=IDLE.
- Latency: accept on edge N, then shift edges N+1..N+8. out_valid is high from just after edge N+8.
- Minimum word period is 10 cycles: accept, 8 shifts, 1 HOLD cycle with out_ready=1, then IDLE.
- Backpressure: with out_ready=0, HOLD persists indefinitely with out_data unchanged. in_ready stays 0.
- in_valid held high while busy: the word is not taken. It is accepted on the first IDLE cycle.
- Reset mid-SHIFT or mid-HOLD: immediately returns to IDLE and all registers take their reset values. The in-flight word is discarded and no out_valid pulse is produced.
- Output is a registered/state decode only. There is no combinational path from in_* or out_ready to out_valid/out_data. in_ready depends on state only.

## Test plan
- Reset, then in_data=8'h80, inject_err=0, out_ready=1 -> out_valid asserts exactly 8 cycles after the accept edge with out_data=12'h80E, then it is consumed and in_ready=1 the next cycle.
- Words 8'h01, 8'hFF, 8'h00 in sequence -> out_data = 12'h013, 12'hFF4 and 12'h000 respectively. Each is 10 cycles apart with in_valid held high.
- in_data=8'hFF, inject_err=1 -> out_data=12'hFF5. Feeding it to the decoder stage flags error_detected; the same word with inject_err=0 gives no error.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data holds 12'h80E, in_ready=0 and busy=1 throughout. Raising out_ready produces exactly one handshake.
- Assert rst at the 4th SHIFT cycle of word 8'hA5 -> out_valid stays 0 and all outputs return to reset values. The next word 8'h01 yields 12'h013 with normal latency.
- Toggle in_data and inject_err while busy -> the captured codeword is unaffected.
